// File: rtl/pe_drv_pkg.sv
// Shared types and defaults for the PE_64 stream driver.
package pe_drv_pkg;
  localparam int DEF_A_W     = 8;
  localparam int DEF_B_W     = 19;
  localparam int DEF_D_W     = 19;
  localparam int DEF_SHIFT_W = 5;
  localparam int DEF_LEN_W   = 8;

  // Cycles after RST during which err_spurious may flag returns that were
  // already in the PE pipeline when the tile was abandoned.
  localparam int PIPE_FLUSH  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2
  } drv_state_e;
endpackage

// File: rtl/pe_stream_driver.sv
// Transmit-side feeder for one PE_64: latches a tile config, forwards the
// operand stream with one cycle of latency, flips the double-buffer select
// once per tile and counts PE returns to detect the end of the tile.
// Build option: PE_DRV_ZERO_BUBBLE_EN zeroes a/b/d on non-beat cycles;
// without it a/b/d hold the last transmitted beat.
module pe_stream_driver
  import pe_drv_pkg::*;
#(
  parameter int A_W     = DEF_A_W,
  parameter int B_W     = DEF_B_W,
  parameter int D_W     = DEF_D_W,
  parameter int SHIFT_W = DEF_SHIFT_W,
  parameter int LEN_W   = DEF_LEN_W
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [SHIFT_W-1:0] cfg_shift,
  input  logic               host_valid,
  output logic               host_ready,
  input  logic [A_W-1:0]     host_a,
  input  logic [B_W-1:0]     host_b,
  input  logic [D_W-1:0]     host_d,
  output logic [A_W-1:0]     pe_in_a,
  output logic [B_W-1:0]     pe_in_b,
  output logic [D_W-1:0]     pe_in_d,
  output logic               pe_in_valid,
  output logic [SHIFT_W-1:0] pe_in_control_shift,
  output logic               pe_in_control_propagate,
  input  logic               pe_out_valid,
  output logic               done,
  output logic               err_spurious
);

  localparam logic [LEN_W-1:0] ONE = {{(LEN_W-1){1'b0}}, 1'b1};

  drv_state_e         state, state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [SHIFT_W-1:0] shift_q;
  logic [LEN_W-1:0]   beat_cnt;
  logic [LEN_W-1:0]   ret_cnt;
  logic               prop_reg;

  logic               cfg_fire;
  logic               host_fire;
  logic               last_beat;
  logic               ret_full;
  logic               ret_done;
  logic               spurious;

  assign cfg_fire  = cfg_ready & cfg_valid;
  assign host_fire = host_ready & host_valid;
  assign last_beat = host_fire && ((beat_cnt + ONE) == len_q);
  assign ret_full  = (ret_cnt == len_q);
  // The final return counts in the same cycle it arrives.
  assign ret_done  = ret_full || (pe_out_valid && ((ret_cnt + ONE) == len_q));
  assign spurious  = pe_out_valid && ((state == IDLE) || ret_full);

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cfg_valid && (cfg_len != '0)) state_nxt = STREAM;
      STREAM:  if (last_beat)                    state_nxt = DRAIN;
      DRAIN:   if (ret_done)                     state_nxt = IDLE;
      default:                                   state_nxt = IDLE;
    endcase
  end

  // Handshake readies come from the state register alone.
  always_comb begin
    cfg_ready  = 1'b0;
    host_ready = 1'b0;
    case (state)
      IDLE:    cfg_ready  = 1'b1;
      STREAM:  host_ready = 1'b1;
      default: ;
    endcase
  end

  // Tile config, double-buffer select and beat/return counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      len_q    <= '0;
      shift_q  <= '0;
      beat_cnt <= '0;
      ret_cnt  <= '0;
      prop_reg <= 1'b0;
    end else begin
      if (cfg_fire && (cfg_len != '0)) begin
        len_q    <= cfg_len;
        shift_q  <= cfg_shift;
        beat_cnt <= '0;
        ret_cnt  <= '0;
        prop_reg <= ~prop_reg;
      end else begin
        if (host_fire) beat_cnt <= beat_cnt + ONE;
        // Saturate at len so a stray return never wraps the counter.
        if (pe_out_valid && (state != IDLE) && !ret_full) ret_cnt <= ret_cnt + ONE;
      end
    end
  end

  // PE input register bank: one-cycle forward of each accepted beat.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pe_in_a                 <= '0;
      pe_in_b                 <= '0;
      pe_in_d                 <= '0;
      pe_in_valid             <= 1'b0;
      pe_in_control_shift     <= '0;
      pe_in_control_propagate <= 1'b0;
    end else begin
      pe_in_valid <= host_fire;
      if (host_fire) begin
        pe_in_a                 <= host_a;
        pe_in_b                 <= host_b;
        pe_in_d                 <= host_d;
        pe_in_control_shift     <= shift_q;
        pe_in_control_propagate <= prop_reg;
      end else begin
`ifdef PE_DRV_ZERO_BUBBLE_EN
        pe_in_a <= '0;
        pe_in_b <= '0;
        pe_in_d <= '0;
`endif
      end
    end
  end

  // Completion pulse and sticky spurious-return flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      done         <= 1'b0;
      err_spurious <= 1'b0;
    end else begin
      done <= (cfg_fire && (cfg_len == '0)) || ((state == DRAIN) && ret_done);
      if (spurious) err_spurious <= 1'b1;
    end
  end

endmodule

// File: doc/pe_stream_driver.md
# pe_stream_driver

Transmit-side feeder for one `PE_64` systolic processing element behind its registered top wrapper. It takes per-tile configuration and a ready/valid operand stream from the tile buffer, and drives the PE input bundle: `a`, `b`, `d`, `valid`, `control_shift` and `control_propagate`. It flips the propagate (double-buffer select) bit once per tile, then counts the valid beats returned by the PE to decide when the tile has drained. Completion is reported to the array controller.

## Interface
Parameters:
- A_W, 8, operand-a width
- B_W, 19, operand-b width
- D_W, 19, operand-d (preload/accumulate) width
- SHIFT_W, 5, control_shift width
- LEN_W, 8, beat-count width per tile

Ports:
- Clock and reset: one clock `CLK`; reset `RST` is synchronous and active-high.
- CLK  in  1  clock
- RST  in  1  synchronous, active-high reset
- cfg_valid  in  1  tile config offered
- cfg_ready  out  1  config accepted (high only in IDLE)
- cfg_len  in  LEN_W  beats in tile
- cfg_shift  in  SHIFT_W  shift for tile
- host_valid  in  1  operand beat offered
- host_ready  out  1  beat accepted (high only in STREAM)
- host_a  in  A_W  operand a
- host_b  in  B_W  operand b
- host_d  in  D_W  operand d
- pe_in_a  out  A_W  to wrapper io_in_a1
- pe_in_b  out  B_W  to wrapper io_in_b1
- pe_in_d  out  D_W  to wrapper io_in_d1
- pe_in_valid  out  1  to wrapper io_in_valid1
- pe_in_control_shift  out  SHIFT_W  to wrapper io_in_control_shift1
- pe_in_control_propagate  out  1  to wrapper io_in_control_propagate1
- pe_out_valid  in  1  from wrapper io_out_valid1
- done  out  1  one-cycle pulse, tile drained
- err_spurious  out  1  sticky: unexpected pe_out_valid

## Operation
- States:
  - IDLE: cfg_ready=1.
  - STREAM: host_ready=1.
  - DRAIN: both readies low.
- IDLE, cfg_valid=1, cfg_len≠0:
  - Latch len and shift; clear beat_cnt and ret_cnt.
  - Toggle prop_reg.
  - Go to STREAM.
- IDLE, cfg_valid=1, cfg_len=0: config is consumed, prop_reg is not toggled, done pulses next cycle, state stays IDLE.
- STREAM, each host handshake:
  - Register a/b/d onto pe_in_*, with pe_in_valid=1, pe_in_control_shift=latched shift, pe_in_control_propagate=prop_reg.
  - beat_cnt++.
  - On the beat where beat_cnt reaches len, go to DRAIN.
- STREAM, no handshake (bubble): pe_in_valid=0; shift and propagate outputs hold; a/b/d handled per Configuration.
- ret_cnt increments on every pe_out_valid while in STREAM or DRAIN.
- DRAIN:
  - pe_in_valid=0.
  - When ret_cnt==len (including the cycle a final pe_out_valid arrives), pulse done and go to IDLE.
- pe_out_valid in IDLE, or when ret_cnt already equals len, sets err_spurious. Only RST clears it.
- Counters are LEN_W bits and never wrap, because len ≤ 2^LEN_W−1.

## Timing
- Reset: every output register is 0 (pe_in_* all zero, prop_reg=0, done=0, err_spurious=0). State is IDLE, so cfg_ready=1 and host_ready=0 in the first cycle after reset.
- cfg_ready and host_ready are decoded combinationally from the state register only. They never depend on a valid input.
- Config accepted at cycle T:
  - STREAM is active at T+1; the first host beat can be accepted at T+1.
  - New propagate is visible on pe_in_control_propagate with that beat, at T+2.
- Host beat accepted at t appears on pe_in_* at t+1. Latency is 1 and throughput is 1 beat/cycle.
- Last beat accepted at t: DRAIN at t+1, host_ready=0 from t+1.
- Final return at cycle r: done is high at r+1, IDLE (cfg_ready=1) at r+1. The next config can be accepted in that same cycle.
- Reset mid-tile:
  - The tile is abandoned with no done pulse.
  - prop_reg returns to 0.
  - Returns still in flight after reset land in IDLE and set err_spurious. The controller must ignore err_spurious for PIPE_FLUSH cycles after RST. PIPE_FLUSH is a package constant, default 4.

## Configuration
- PE_DRV_ZERO_BUBBLE_EN defined: on bubble and DRAIN cycles, pe_in_a, pe_in_b and pe_in_d are driven to 0.
- PE_DRV_ZERO_BUBBLE_EN undefined: they hold the last transmitted values, so no toggling reaches the PE datapath.
- pe_in_valid, shift and propagate behaviour is identical in both builds.

## Structure
- Package `pe_drv_pkg` holds:
  - default widths A_W, B_W, D_W, SHIFT_W, LEN_W
  - the state enum (IDLE, STREAM, DRAIN)
  - PIPE_FLUSH
- Single module. Counters and the output register bank are inline; no sub-module is warranted.

## Test plan
- Bench: DUT drives `top_PE_64`, or a 3-cycle valid-loopback model of it.
- Reset: hold RST 2 cycles, then check every output is 0, cfg_ready=1, host_ready=0.
- Basic tile: cfg_len=4, cfg_shift=3, four back-to-back beats a=1..4 → pe_in_valid high for 4 consecutive cycles with shift=3 and propagate=1; done one cycle after the 4th pe_out_valid.
- Propagate alternation: three tiles of len=2 → propagate is 1, 0, 1; each new config accepted the cycle done pulses.
- Bubbles: len=3, with host_valid low on the cycle after beat 1 → pe_in_valid pattern is 1,0,1,1. Bubble a/b/d are 0 with the macro defined and equal to beat-1 values without it.
- Zero length: cfg_len=0 → done the next cycle, host_ready never asserts, propagate unchanged.
- Mid-tile reset and spurious return: RST after 2 of 5 beats → propagate=0, state IDLE, no done. A forced pe_out_valid in IDLE sets err_spurious, which stays set until the next RST.
